// File: rtl/bus_dma.sv
// rtl/bus_dma.sv - word-granular memory-to-memory DMA engine with a 4-register config port
// Copies LEN words SRC->DST as read/write pairs on the host bus; completion raises sticky done and irq.
module bus_dma #(
  parameter int LEN_BITS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [3:0]  cfg_wmask,
  input  logic        cfg_wen,
  input  logic        cfg_ren,
  input  logic        cfg_active,
  output logic [31:0] cfg_rdata,
  output logic        cfg_done,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wmask,
  output logic        bus_wen,
  output logic        bus_ren,
  input  logic [31:0] bus_rdata,
  input  logic        bus_done,
  output logic        irq
);
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_FIN} state_t;

  state_t              state_q, state_d;
  logic [31:0]         src_q, src_d, dst_q, dst_d;
  logic [31:0]         cur_src_q, cur_src_d, cur_dst_q, cur_dst_d, hold_q, hold_d;
  logic [LEN_BITS-1:0] len_q, len_d, rem_q, rem_d;
  logic                irq_en_q, irq_en_d, done_q, done_d, abort_q, abort_d;
  logic                strobe_q, strobe_d, cfg_wait_q, cfg_wait_d, cfg_done_q, cfg_done_d;
  logic [31:0]         cfg_rdata_q, cfg_rdata_d;

  logic        busy, accept, cfg_wr, ctrl_wr, start, abort_req;
  logic [31:0] rd_mux;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^{cfg_addr[31:4], cfg_addr[1:0]};

  assign busy      = (state_q != S_IDLE);
  // One access per strobe assertion: cfg_wait_q blocks re-acceptance until the strobes drop.
  assign accept    = cfg_active && (cfg_wen || cfg_ren) && !cfg_wait_q;
  assign cfg_wr    = accept && cfg_wen && (cfg_wmask == 4'hF);
  assign ctrl_wr   = cfg_wr && (cfg_addr[3:2] == 2'd3);
  assign start     = ctrl_wr && cfg_wdata[0] && !busy;
  assign abort_req = ctrl_wr && cfg_wdata[4] && busy;

  always_comb begin
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    irq_en_d    = irq_en_q;
    rd_mux      = 32'h0;
    cfg_wait_d  = cfg_wait_q;
    if (cfg_wr && !busy) begin
      case (cfg_addr[3:2])
        2'd0:    src_d = {cfg_wdata[31:2], 2'b00};
        2'd1:    dst_d = {cfg_wdata[31:2], 2'b00};
        2'd2:    len_d = cfg_wdata[LEN_BITS-1:0];
        default: ;
      endcase
    end
    if (ctrl_wr) irq_en_d = cfg_wdata[3];
    case (cfg_addr[3:2])
      2'd0:    rd_mux = src_q;
      2'd1:    rd_mux = dst_q;
      2'd2:    rd_mux = {{(32-LEN_BITS){1'b0}}, len_q};
      default: rd_mux = {27'h0, 1'b0, irq_en_q, done_q, busy, 1'b0};
    endcase
    if (accept) cfg_wait_d = 1'b1;
    else if (!cfg_wen && !cfg_ren) cfg_wait_d = 1'b0;
    cfg_done_d  = accept;
    cfg_rdata_d = (accept && cfg_ren) ? rd_mux : 32'h0;
  end

  // Strobe is raised one cycle after entering RD/WR, giving the idle cycle between transactions.
  always_comb begin
    state_d   = state_q;
    strobe_d  = strobe_q;
    cur_src_d = cur_src_q;
    cur_dst_d = cur_dst_q;
    rem_d     = rem_q;
    hold_d    = hold_q;
    abort_d   = abort_q || abort_req;
    done_d    = done_q && !(ctrl_wr && cfg_wdata[2]);
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          if (len_q != '0) begin
            cur_src_d = src_q;
            cur_dst_d = dst_q;
            rem_d     = len_q;
            state_d   = S_RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RD: begin
        if (!strobe_q) begin
          strobe_d = 1'b1;
        end else if (bus_done) begin
          strobe_d = 1'b0;
          hold_d   = bus_rdata;
          state_d  = S_WR;
        end
      end
      S_WR: begin
        if (!strobe_q) begin
          strobe_d = 1'b1;
        end else if (bus_done) begin
          strobe_d  = 1'b0;
          cur_src_d = cur_src_q + 32'd4;
          cur_dst_d = cur_dst_q + 32'd4;
          rem_d     = rem_q - LEN_BITS'(1);
          state_d   = (rem_q == LEN_BITS'(1) || abort_d) ? S_FIN : S_RD;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      src_q       <= 32'h0;
      dst_q       <= 32'h0;
      len_q       <= '0;
      cur_src_q   <= 32'h0;
      cur_dst_q   <= 32'h0;
      rem_q       <= '0;
      hold_q      <= 32'h0;
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      strobe_q    <= 1'b0;
      cfg_wait_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      len_q       <= len_d;
      cur_src_q   <= cur_src_d;
      cur_dst_q   <= cur_dst_d;
      rem_q       <= rem_d;
      hold_q      <= hold_d;
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      strobe_q    <= strobe_d;
      cfg_wait_q  <= cfg_wait_d;
      cfg_done_q  <= cfg_done_d;
      cfg_rdata_q <= cfg_rdata_d;
    end
  end

  assign bus_ren   = strobe_q && (state_q == S_RD);
  assign bus_wen   = strobe_q && (state_q == S_WR);
  assign bus_addr  = (state_q == S_WR) ? cur_dst_q : ((state_q == S_RD) ? cur_src_q : 32'h0);
  assign bus_wdata = (state_q == S_WR) ? hold_q : 32'h0;
  assign bus_wmask = 4'hF;
  assign cfg_done  = cfg_done_q;
  assign cfg_rdata = cfg_rdata_q;
  assign irq       = done_q && irq_en_q;
endmodule

// File: tb/tb_bus_dma.sv
// tb/tb_bus_dma.sv - directed self-checking bench for bus_dma
// Memory model answers bus requests with configurable latency and logs every completed transaction.
module tb_bus_dma;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] cfg_addr = 32'h0, cfg_wdata = 32'h0;
  logic [3:0]  cfg_wmask = 4'h0;
  logic        cfg_wen = 1'b0, cfg_ren = 1'b0, cfg_active = 1'b0;
  logic [31:0] cfg_rdata;
  logic        cfg_done;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wmask;
  logic        bus_wen, bus_ren;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_done = 1'b0;
  logic        irq;

  always #5 clk = ~clk;

  bus_dma #(.LEN_BITS(16)) dut (
    .clk(clk), .rst(rst),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wmask(cfg_wmask),
    .cfg_wen(cfg_wen), .cfg_ren(cfg_ren), .cfg_active(cfg_active),
    .cfg_rdata(cfg_rdata), .cfg_done(cfg_done),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
    .bus_wen(bus_wen), .bus_ren(bus_ren), .bus_rdata(bus_rdata), .bus_done(bus_done),
    .irq(irq)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [0:1023];
  logic [32:0] ev_q [$];
  int          n_wr = 0, viol = 0, fixed_lat = 1, cur_lat = 1, wait_cnt = 0;
  bit          rand_lat = 1'b0;
  logic        prev_act = 1'b0, prev_ren = 1'b0, prev_wen = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_wdata = 32'h0;

  always @(negedge clk) begin
    if (bus_ren && bus_wen) viol++;
    if (bus_wmask !== 4'hF) viol++;
    if (prev_act && !bus_done && rst)
      if (bus_ren !== prev_ren || bus_wen !== prev_wen || bus_addr !== prev_addr || bus_wdata !== prev_wdata)
        viol++;
    prev_act   = bus_ren || bus_wen;
    prev_ren   = bus_ren;
    prev_wen   = bus_wen;
    prev_addr  = bus_addr;
    prev_wdata = bus_wdata;
    if (bus_done) begin
      bus_done  = 1'b0;
      bus_rdata = 32'h0;
    end else if (bus_ren || bus_wen) begin
      if (wait_cnt >= cur_lat) begin
        bus_done = 1'b1;
        wait_cnt = 0;
        ev_q.push_back({bus_wen, bus_addr});
        if (bus_ren) bus_rdata = mem[bus_addr[11:2]];
        else begin
          mem[bus_addr[11:2]] = bus_wdata;
          n_wr++;
        end
        cur_lat = rand_lat ? int'($urandom_range(7, 0)) : fixed_lat;
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg_access(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                            input logic wr, output logic [31:0] rdata);
    @(negedge clk);
    cfg_addr = addr; cfg_wdata = data; cfg_wmask = mask;
    cfg_wen = wr; cfg_ren = !wr; cfg_active = 1'b1;
    @(negedge clk);
    check("cfg_done_pulse", cfg_done, 1);
    rdata = cfg_rdata;
    cfg_wen = 1'b0; cfg_ren = 1'b0; cfg_active = 1'b0;
  endtask

  task automatic cfg_wr(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    cfg_access(addr, data, 4'hF, 1'b1, d);
  endtask

  task automatic cfg_rd(input logic [31:0] addr, output logic [31:0] data);
    cfg_access(addr, 32'h0, 4'h0, 1'b0, data);
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] s;
    int n, bad;
    n = 0; bad = 0;
    do begin
      cfg_rd(32'hC, s);
      n++;
      if (s[1] == s[2]) bad++;
    end while (s[1] && n < 500);
    check({tag, "_idle_timeout"}, s[1], 0);
    check({tag, "_busy_xor_done"}, bad, 0);
  endtask

  initial begin
    logic [31:0] r;
    int n, bad;

    repeat (3) @(negedge clk);
    check("rst_bus_ren", bus_ren, 0);
    check("rst_bus_wen", bus_wen, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_wdata", bus_wdata, 0);
    check("rst_bus_wmask", bus_wmask, 4'hF);
    check("rst_cfg_done", cfg_done, 0);
    check("rst_cfg_rdata", cfg_rdata, 0);
    check("rst_irq", irq, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_rd(32'(i * 4), r);
      check("rst_reg_read", r, 0);
    end

    cfg_access(32'h0, 32'h1234, 4'h3, 1'b1, r);
    cfg_rd(32'h0, r);
    check("partial_mask_ignored", r, 0);

    @(negedge clk);
    cfg_addr = 32'h8; cfg_ren = 1'b1; cfg_active = 1'b1;
    @(negedge clk); check("held_strobe_c1", cfg_done, 1);
    @(negedge clk); check("held_strobe_c2", cfg_done, 0);
    @(negedge clk); check("held_strobe_c3", cfg_done, 0);
    cfg_ren = 1'b0; cfg_active = 1'b0;

    for (int i = 0; i < 4; i++) begin
      mem[64 + i]  = 32'hA5A5_0000 + 32'(i);
      mem[128 + i] = 32'h0;
    end
    ev_q.delete();
    cfg_wr(32'h0, 32'h100);
    cfg_wr(32'h4, 32'h200);
    cfg_wr(32'h8, 32'd4);
    cfg_wr(32'hC, 32'h9);
    wait_idle("t1");
    check("t1_ev_count", ev_q.size(), 8);
    for (int i = 0; i < 4; i++) begin
      check("t1_rd_ev", ev_q[2 * i], {1'b0, 32'h100 + 32'(4 * i)});
      check("t1_wr_ev", ev_q[2 * i + 1], {1'b1, 32'h200 + 32'(4 * i)});
      check("t1_copy", mem[128 + i], 32'hA5A5_0000 + 32'(i));
    end
    cfg_rd(32'hC, r);
    check("t1_status", r, 32'hC);
    check("t1_irq", irq, 1);
    cfg_wr(32'hC, 32'h4);
    check("t1_irq_cleared", irq, 0);
    cfg_rd(32'hC, r);
    check("t1_status_cleared", r, 0);

    ev_q.delete();
    cfg_wr(32'h8, 32'd0);
    cfg_wr(32'hC, 32'h1);
    cfg_rd(32'hC, r);
    check("len0_status", r, 32'h4);
    repeat (5) @(negedge clk);
    check("len0_no_bus", ev_q.size(), 0);
    cfg_wr(32'hC, 32'h4);

    rand_lat = 1'b1;
    viol = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    ev_q.delete();
    cfg_wr(32'h0, 32'h0);
    cfg_wr(32'h4, 32'h400);
    cfg_wr(32'h8, 32'd16);
    cfg_wr(32'hC, 32'h1);
    wait_idle("rnd");
    check("rnd_ev_count", ev_q.size(), 32);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (mem[256 + i] !== mem[i]) bad++;
      if (ev_q[2 * i][32] !== 1'b0 || ev_q[2 * i + 1][32] !== 1'b1) bad++;
    end
    check("rnd_copy_order", bad, 0);
    check("rnd_protocol", viol, 0);
    cfg_wr(32'hC, 32'h4);
    rand_lat = 1'b0;

    fixed_lat = 5; cur_lat = 5;
    for (int i = 0; i < 10; i++) mem[64 + i] = 32'hC0DE_0000 + 32'(i);
    cfg_wr(32'h0, 32'h100);
    cfg_wr(32'h4, 32'h600);
    cfg_wr(32'h8, 32'd10);
    ev_q.delete();
    n_wr = 0;
    cfg_wr(32'hC, 32'h1);
    n = 0;
    while (!(n_wr == 2 && bus_ren) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("abort_wait_timeout", n < 400, 1);
    cfg_wr(32'hC, 32'h10);
    wait_idle("abort");
    check("abort_writes", n_wr, 3);
    check("abort_third_copy", mem[384 + 2], 32'hC0DE_0002);
    cfg_rd(32'hC, r);
    check("abort_status", r, 32'h4);
    cfg_rd(32'h0, r);
    check("abort_src_kept", r, 32'h100);
    cfg_rd(32'h8, r);
    check("abort_len_kept", r, 32'd10);
    cfg_wr(32'hC, 32'h4);

    fixed_lat = 2; cur_lat = 2;
    mem[1023] = 32'hDEAD_0001;
    mem[0]    = 32'hBEEF_0002;
    cfg_wr(32'h0, 32'hFFFF_FFFC);
    cfg_wr(32'h4, 32'h700);
    cfg_wr(32'h8, 32'd2);
    ev_q.delete();
    cfg_wr(32'hC, 32'h1);
    cfg_wr(32'h4, 32'h300);
    cfg_rd(32'h4, r);
    check("busy_dst_write_ignored", r, 32'h700);
    wait_idle("wrap");
    check("wrap_ev_count", ev_q.size(), 4);
    check("wrap_rd0_addr", ev_q[0], {1'b0, 32'hFFFF_FFFC});
    check("wrap_rd1_addr", ev_q[2], {1'b0, 32'h0});
    check("wrap_copy0", mem[448], 32'hDEAD_0001);
    check("wrap_copy1", mem[449], 32'hBEEF_0002);
    cfg_wr(32'hC, 32'h4);

    fixed_lat = 6; cur_lat = 6;
    cfg_wr(32'h0, 32'h100);
    cfg_wr(32'h4, 32'h200);
    cfg_wr(32'h8, 32'd8);
    cfg_wr(32'hC, 32'h9);
    n = 0;
    while (!bus_wen && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("rst_wait_timeout", n < 400, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_wen", bus_wen, 0);
    check("async_rst_ren", bus_ren, 0);
    check("async_rst_addr", bus_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_rd(32'(i * 4), r);
      check("post_rst_reg", r, 0);
    end
    check("post_rst_irq", irq, 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_ren || bus_wen) bad++;
    end
    check("post_rst_bus_idle", bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
